// File: rtl/q_debounce_edge_if.sv
// Bus bundle between a debouncer client and q_debounce_edge.
//   q_in        raw Q from the upstream D flip-flop
//   count_clr   synchronous clear of edge_count / cnt_sat
//   db_out      debounced level
//   rise_pulse  one-cycle pulse on an accepted 0->1
//   fall_pulse  one-cycle pulse on an accepted 1->0
//   edge_count  saturating count of accepted rising edges
//   cnt_sat     sticky flag, edge_count reached all-ones
// master drives q_in/count_clr; slave (the debouncer) drives the rest.
interface q_debounce_edge_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             q_in;
  logic             count_clr;
  logic             db_out;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] edge_count;
  logic             cnt_sat;

  modport master (
    output q_in,
    output count_clr,
    input  db_out,
    input  rise_pulse,
    input  fall_pulse,
    input  edge_count,
    input  cnt_sat
  );

  modport slave (
    input  q_in,
    input  count_clr,
    output db_out,
    output rise_pulse,
    output fall_pulse,
    output edge_count,
    output cnt_sat
  );
endinterface

// File: rtl/q_debounce_edge.sv
// Debouncer and edge detector for the Q output of an upstream flop.
// q_in is synchronised through SYNC_STAGES flops, then a change of level is only
// accepted once STABLE_CYCLES consecutive synced samples agree on the new value.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   q_debounce_edge_if.slave: q_in/count_clr in; db_out, rise_pulse,
//         fall_pulse, edge_count, cnt_sat out (all registered)
module q_debounce_edge #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input logic              clk,
  input logic              rst,
  q_debounce_edge_if.slave bus
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EdgeMax = '1;

  typedef enum logic [1:0] {
    StLow,
    StChkHi,
    StHigh,
    StChkLo
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       edge_count_q, edge_count_d;
  logic                   cnt_sat_q, cnt_sat_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.q_in};
    end
  end

  // Stability FSM: the CHK states count consecutive samples of the candidate level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StLow: begin
        if (s) begin
          state_d = StChkHi;
          cnt_d   = CntW'(1);
        end
      end
      StChkHi: begin
        if (!s) begin
          state_d = StLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StHigh;
          cnt_d   = '0;
          db_d    = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (!s) begin
          state_d = StChkLo;
          cnt_d   = CntW'(1);
        end
      end
      StChkLo: begin
        if (s) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StLow;
          cnt_d   = '0;
          db_d    = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StLow;
        cnt_d   = '0;
      end
    endcase
  end

  // Edge counter advances on the same edge that raises rise_pulse; clear has priority.
  always_comb begin
    edge_count_d = edge_count_q;
    cnt_sat_d    = cnt_sat_q;
    if (bus.count_clr) begin
      edge_count_d = '0;
      cnt_sat_d    = 1'b0;
    end else if (rise_d) begin
      if (edge_count_q != EdgeMax) begin
        edge_count_d = edge_count_q + 1'b1;
      end
      if (edge_count_d == EdgeMax) begin
        cnt_sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StLow;
      cnt_q        <= '0;
      db_q         <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      edge_count_q <= '0;
      cnt_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      db_q         <= db_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      edge_count_q <= edge_count_d;
      cnt_sat_q    <= cnt_sat_d;
    end
  end

  assign bus.db_out     = db_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.edge_count = edge_count_q;
  assign bus.cnt_sat    = cnt_sat_q;

endmodule

// File: tb/tb_q_debounce_edge.sv
// Bench for q_debounce_edge: two instances (CNT_W=8 and CNT_W=2) share q_in and
// count_clr. Each driven cycle pushes the reference model's expected outputs into a
// queue; a monitor pops one entry after every non-reset clock edge and compares.
module tb_q_debounce_edge;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic q_in = 1'b0;
  logic count_clr = 1'b0;

  always #10 clk = ~clk;

  q_debounce_edge_if #(.CNT_W(8)) bus8 ();
  q_debounce_edge_if #(.CNT_W(2)) bus2 ();

  assign bus8.q_in      = q_in;
  assign bus8.count_clr = count_clr;
  assign bus2.q_in      = q_in;
  assign bus2.count_clr = count_clr;

  q_debounce_edge #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .CNT_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  q_debounce_edge #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct packed {
    logic       db;
    logic       rise;
    logic       fall;
    logic [7:0] c8;
    logic       s8;
    logic [1:0] c2;
    logic       s2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model: delay line of raw samples plus a run length of samples that
  // disagree with the current debounced level.
  logic m_hist[$];
  logic m_level;
  int   m_run;
  int   m_c8, m_c2;
  logic m_s8, m_s2;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    m_level = 1'b0;
    m_run   = 0;
    m_c8    = 0;
    m_c2    = 0;
    m_s8    = 1'b0;
    m_s2    = 1'b0;
  endtask

  task automatic model_edge(input logic q, input logic clr);
    exp_t e;
    logic s;
    s = m_hist.pop_front();
    m_hist.push_back(q);
    e = '0;
    if (s != m_level) m_run++;
    else m_run = 0;
    if (m_run == STABLE) begin
      m_level = s;
      m_run   = 0;
      if (s) e.rise = 1'b1;
      else e.fall = 1'b1;
    end
    if (clr) begin
      m_c8 = 0; m_s8 = 1'b0;
      m_c2 = 0; m_s2 = 1'b0;
    end else if (e.rise) begin
      if (m_c8 < 255) m_c8++;
      if (m_c8 == 255) m_s8 = 1'b1;
      if (m_c2 < 3) m_c2++;
      if (m_c2 == 3) m_s2 = 1'b1;
    end
    e.db = m_level;
    e.c8 = 8'(m_c8);
    e.s8 = m_s8;
    e.c2 = 2'(m_c2);
    e.s2 = m_s2;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and record what should follow.
  task automatic step(input logic q, input logic clr);
    @(negedge clk);
    q_in      = q;
    count_clr = clr;
    model_edge(q, clr);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " db8"},   32'(bus8.db_out), 0);
    chk({tag, " rise8"}, 32'(bus8.rise_pulse), 0);
    chk({tag, " fall8"}, 32'(bus8.fall_pulse), 0);
    chk({tag, " cnt8"},  32'(bus8.edge_count), 0);
    chk({tag, " sat8"},  32'(bus8.cnt_sat), 0);
    chk({tag, " db2"},   32'(bus2.db_out), 0);
    chk({tag, " fall2"}, 32'(bus2.fall_pulse), 0);
    chk({tag, " cnt2"},  32'(bus2.edge_count), 0);
  endtask

  // Assert reset between clock edges, check outputs at once, hold 3 cycles, release.
  task automatic do_reset(input string tag);
    @(negedge clk);
    q_in      = 1'b0;
    count_clr = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: one expected entry per post-reset clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("db_out8",     32'(bus8.db_out),     32'(e.db));
        chk("rise_pulse8", 32'(bus8.rise_pulse), 32'(e.rise));
        chk("fall_pulse8", 32'(bus8.fall_pulse), 32'(e.fall));
        chk("edge_count8", 32'(bus8.edge_count), 32'(e.c8));
        chk("cnt_sat8",    32'(bus8.cnt_sat),    32'(e.s8));
        chk("db_out2",     32'(bus2.db_out),     32'(e.db));
        chk("rise_pulse2", 32'(bus2.rise_pulse), 32'(e.rise));
        chk("fall_pulse2", 32'(bus2.fall_pulse), 32'(e.fall));
        chk("edge_count2", 32'(bus2.edge_count), 32'(e.c2));
        chk("cnt_sat2",    32'(bus2.cnt_sat),    32'(e.s2));
      end
    end
  end

  initial begin
    model_reset();
    do_reset("reset");
    repeat (3) step(1'b0, 1'b0);

    // Clean rise then clean fall.
    repeat (10) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Three-cycle glitch is rejected, four cycles is accepted.
    repeat (3) step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Saturate the narrow counter, then clear.
    repeat (4) begin
      repeat (8) step(1'b1, 1'b0);
      repeat (8) step(1'b0, 1'b0);
    end
    step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);

    // Clear coincident with the rise edge (edge 6 after q_in first sampled high).
    repeat (5) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0);

    // Toggle every cycle while HIGH: outputs must stay put.
    for (int i = 0; i < 20; i++) step(1'(i % 2), 1'b0);
    repeat (6) step(1'b1, 1'b0);

    // Reset while checking a fall: no fall pulse, back to LOW.
    repeat (4) step(1'b0, 1'b0);
    do_reset("reset mid-check");
    repeat (8) step(1'b0, 1'b0);

    // Randomised runs of constant level with occasional clears.
    for (int seg = 0; seg < 300; seg++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) step(v, $urandom_range(0, 15) == 0);
    end
    repeat (10) step(1'b0, 1'b0);

    @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
